// File: rtl/data_mem_ctrl_if.sv
// Request/done bus between the control unit (master) and the data memory (slave).
//
// Handshake: the master raises req with we/ld_signed/size/addr/wdata stable.
// The slave samples them on a rising edge where busy=0 and req=1. That edge is
// the accept edge, and busy rises from it. While busy=1 all master signals are
// ignored. Completion is a single-cycle done pulse with busy=0. err and rdata are
// qualified by done. rdata holds its value until the next done. A req that is
// present during the done cycle is accepted at the end of that cycle.
interface data_mem_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 15
);
  logic              req;
  logic              we;
  logic              ld_signed;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, ld_signed, size, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, we, ld_signed, size, addr, wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory behind an IDLE -> WAIT -> ACCESS request FSM.
// Supports sub-word signed/unsigned loads, lane-masked stores, programmable
// wait states, and error reporting for misaligned, oversized or out-of-range
// accesses. A rejected access leaves the RAM untouched and still takes the
// full latency.
module data_mem_ctrl #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 15,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_ctrl_if.slave        bus,
  output logic [1:0]            dbg_state_o
);

  localparam int NB     = DATA_W / 8;
  localparam int LOG_NB = $clog2(NB);
  localparam int IDX_W  = ADDR_W - LOG_NB;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Operation captured at the accept edge
  logic              we_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              mem_we;

  // Decoded access fields
  int                nbytes;
  logic [LOG_NB-1:0] off;
  logic [IDX_W-1:0]  widx;
  logic [MEM_AW-1:0] midx;
  logic              acc_err;

  // Lane data paths
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] rword;
  logic [DATA_W-1:0] rshift;
  logic [DATA_W-1:0] ld_val;
  logic              sign;

  // Decode the captured address into word index, lane offset and error causes
  always_comb begin
    nbytes  = 1 << size_q;
    off     = addr_q[LOG_NB-1:0];
    widx    = addr_q[ADDR_W-1:LOG_NB];
    midx    = widx[MEM_AW-1:0];
    acc_err = (nbytes > NB) ||
              ((int'(off) & (nbytes - 1)) != 0) ||
              (int'(widx) >= DEPTH);
  end

  // Build the store lane mask/data and the extended load value
  always_comb begin
    be     = '0;
    sign   = 1'b0;
    wshift = wdata_q << {off, 3'b000};
    rword  = mem[midx];
    rshift = rword >> {off, 3'b000};
    ld_val = '0;
    for (int b = 0; b < NB; b++) begin
      be[b] = (b >= int'(off)) && (b < int'(off) + nbytes);
      if (b == nbytes - 1) sign = sgn_q & rshift[8*b+7];
    end
    for (int b = 0; b < NB; b++) begin
      ld_val[8*b +: 8] = (b < nbytes) ? rshift[8*b +: 8] : {8{sign}};
    end
  end

  // Next-state and output decisions of the request FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    accept  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = 4'd0;
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == WS_LAST) state_d = S_ACCESS;
        else                  cnt_d   = cnt_q + 4'd1;
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        done_d  = 1'b1;
        if (acc_err) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (we_q) begin
          mem_we  = 1'b1;
        end else begin
          rdata_d = ld_val;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, status and captured-operation registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= bus.we;
        sgn_q   <= bus.ld_signed;
        size_q  <= bus.size;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end

  // RAM write port: only the addressed lanes, and never while reset is asserted
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[midx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rdata   = rdata_q;
  assign dbg_state_o = state_q;

endmodule
